// File: rtl/period_meter_pkg.sv
// Shared types for the period meter: FSM state encoding and a state classifier.
package period_meter_pkg;

    localparam int unsigned DEF_CNT_SIZE    = 16;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_HOLD    = 2'd3
    } state_e;

    function automatic logic is_busy(input state_e s);
        return (s == ST_ARM) || (s == ST_MEASURE);
    endfunction

endpackage

// File: rtl/period_meter_sync_edge.sv
// Multi-stage synchronizer with edge detection; reset value is a parameter so a
// line that is already high at reset release produces no rise.
module sync_edge #(
    parameter int unsigned pStages = 2,
    parameter logic        pRstVal = 1'b1
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iSig,
    output logic oRise_c,
    output logic oFall_c
);

    logic [pStages-1:0] sync_q;
    logic               prev_q;
    logic               level;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            sync_q <= {pStages{pRstVal}};
            prev_q <= pRstVal;
        end else begin
            sync_q <= {sync_q[pStages-2:0], iSig};
            prev_q <= sync_q[pStages-1];
        end
    end

    assign level   = sync_q[pStages-1];
    assign oRise_c = level & ~prev_q;
    assign oFall_c = ~level & prev_q;

endmodule

// File: rtl/period_meter.sv
// Period / high-time meter for one asynchronous input, results delivered over
// a valid/ready handshake. One measurement per arm; the closing rise never opens the next one.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int unsigned pCntSize    = DEF_CNT_SIZE,
    parameter int unsigned pSyncStages = DEF_SYNC_STAGES
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iSig,
    input  logic                iEnable,
    output logic                oValid,
    input  logic                iReady,
    output logic [pCntSize-1:0] oPeriod,
    output logic [pCntSize-1:0] oHigh,
    output logic                oOverflow,
    output logic                oBusy
);

    localparam logic [pCntSize-1:0] CNT_MAX = '1;

    logic rise_c;
    logic fall_c;

    state_e              state_q,     state_d;
    logic [pCntSize-1:0] cnt_q,       cnt_d;
    logic [pCntSize-1:0] high_q,      high_d;
    logic                high_seen_q, high_seen_d;
    logic [pCntSize-1:0] period_q,    period_d;
    logic [pCntSize-1:0] high_out_q,  high_out_d;
    logic                ovf_q,       ovf_d;
    logic                valid_q,     valid_d;
    logic                busy_q,      busy_d;

    sync_edge #(
        .pStages (pSyncStages),
        .pRstVal (1'b1)
    ) u_sync_edge (
        .iClk    (iClk),
        .iRst    (iRst),
        .iSig    (iSig),
        .oRise_c (rise_c),
        .oFall_c (fall_c)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            high_q      <= '0;
            high_seen_q <= 1'b0;
            period_q    <= '0;
            high_out_q  <= '0;
            ovf_q       <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            high_q      <= high_d;
            high_seen_q <= high_seen_d;
            period_q    <= period_d;
            high_out_q  <= high_out_d;
            ovf_q       <= ovf_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and result capture; result registers only change on entry to HOLD.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        high_d      = high_q;
        high_seen_d = high_seen_q;
        period_d    = period_q;
        high_out_d  = high_out_q;
        ovf_d       = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (iEnable) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (!iEnable) begin
                    state_d = ST_IDLE;
                end else if (rise_c) begin
                    cnt_d       = pCntSize'(1);
                    high_d      = '0;
                    high_seen_d = 1'b0;
                    state_d     = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (!iEnable) begin
                    state_d = ST_IDLE;
                end else begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + pCntSize'(1);
                    if (fall_c && !high_seen_q) begin
                        high_d      = cnt_q;
                        high_seen_d = 1'b1;
                    end
                    // A rise at MAX is still an exact result, so it wins over saturation.
                    if (rise_c) begin
                        period_d   = cnt_q;
                        high_out_d = high_q;
                        ovf_d      = 1'b0;
                        state_d    = ST_HOLD;
                    end else if (cnt_q == CNT_MAX) begin
                        period_d   = CNT_MAX;
                        high_out_d = (high_seen_q && !fall_c) ? high_q : CNT_MAX;
                        ovf_d      = 1'b1;
                        state_d    = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (iReady) state_d = iEnable ? ST_ARM : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        valid_d = (state_d == ST_HOLD);
        busy_d  = is_busy(state_d);
    end

    assign oValid    = valid_q;
    assign oPeriod   = period_q;
    assign oHigh     = high_out_q;
    assign oOverflow = ovf_q;
    assign oBusy     = busy_q;

endmodule
